// File: rtl/mux16_scan_pkg.sv
// Shared constants and FSM state encoding for the 16-channel mux scanner.
package mux16_scan_pkg;

    localparam int unsigned MUX_CH = 16;
    localparam int unsigned SEL_W  = 4;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StSample
    } scan_state_e;

endpackage

// File: rtl/mux16_scan_if.sv
// Bus between the scan controller and its environment (requester plus downstream mux16).
interface mux16_scan_if;
    import mux16_scan_pkg::*;

    logic              start;
    logic              continuous;
    logic              abort;
    logic              y;
    logic              s0;
    logic              s1;
    logic              s2;
    logic              s3;
    logic [MUX_CH-1:0] data_out;
    logic              done;
    logic              busy;

    modport master (
        output start, continuous, abort, y,
        input  s0, s1, s2, s3, data_out, done, busy
    );

    modport slave (
        input  start, continuous, abort, y,
        output s0, s1, s2, s3, data_out, done, busy
    );

endinterface

// File: rtl/mux16_scan.sv
// Steps a 4-bit select through all 16 channels of an external mux16, letting each settle
// for SETTLE_CYCLES cycles before sampling y, and publishes the assembled 16-bit word.
module mux16_scan
    import mux16_scan_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input logic         clk,
    input logic         rst_n,
    mux16_scan_if.slave bus
);

    localparam int unsigned          CntW     = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CntW-1:0]      CntLast  = CntW'(SETTLE_CYCLES - 1);
    localparam logic [SEL_W-1:0]     SelLast  = SEL_W'(MUX_CH - 1);

    scan_state_e       state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [MUX_CH-1:0] shadow_q, shadow_d;
    logic [MUX_CH-1:0] data_q, data_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        done_d   = 1'b0;
        busy_d   = busy_q;

        // Abort outranks every other event, including start and the final sample.
        if (bus.abort) begin
            state_d  = StIdle;
            sel_d    = '0;
            cnt_d    = '0;
            shadow_d = '0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_d = StSettle;
                        sel_d   = '0;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                    end
                end
                StSettle: begin
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntLast) begin
                        state_d = StSample;
                    end
                end
                StSample: begin
                    shadow_d[sel_q] = bus.y;
                    cnt_d           = '0;
                    if (sel_q != SelLast) begin
                        sel_d   = sel_q + SEL_W'(1);
                        state_d = StSettle;
                    end else begin
                        // Channel 15 bypasses the shadow so the word is published this edge.
                        data_d = {bus.y, shadow_q[MUX_CH-2:0]};
                        done_d = 1'b1;
                        sel_d  = '0;
                        if (bus.continuous) begin
                            state_d = StSettle;
                            busy_d  = 1'b1;
                        end else begin
                            state_d = StIdle;
                            busy_d  = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    sel_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            sel_q    <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.s0       = sel_q[0];
    assign bus.s1       = sel_q[1];
    assign bus.s2       = sel_q[2];
    assign bus.s3       = sel_q[3];
    assign bus.data_out = data_q;
    assign bus.done     = done_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_mux16_scan.sv
// Bench for mux16_scan: two instances (settle 1 and 3) each driving a modelled mux16;
// published words are checked against a queue of expected scan results.
module tb_mux16_scan;

    logic clk;
    logic rst_n;
    logic [15:0] mux_d;
    int   edge_cnt;
    int   e0;
    int   checks;
    int   failures;
    logic [15:0] exp_a[$];
    logic [15:0] exp_b[$];

    mux16_scan_if if_a ();
    mux16_scan_if if_b ();

    mux16_scan #(.SETTLE_CYCLES(1)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a)
    );

    mux16_scan #(.SETTLE_CYCLES(3)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b)
    );

    // Behavioural mux16: y = d[{s3,s2,s1,s0}].
    assign if_a.y = mux_d[{if_a.s3, if_a.s2, if_a.s1, if_a.s0}];
    assign if_b.y = mux_d[{if_b.s3, if_b.s2, if_b.s1, if_b.s0}];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (if_a.done === 1'b1) begin
            if (exp_a.size() == 0) check_val("a_spurious_done", 1, 0);
            else check_val("a_data_out", {16'h0, if_a.data_out}, {16'h0, exp_a.pop_front()});
        end
        if (if_b.done === 1'b1) begin
            if (exp_b.size() == 0) check_val("b_spurious_done", 1, 0);
            else check_val("b_data_out", {16'h0, if_b.data_out}, {16'h0, exp_b.pop_front()});
        end
    end

    function automatic logic [3:0] sel_a();
        return {if_a.s3, if_a.s2, if_a.s1, if_a.s0};
    endfunction

    function automatic logic [3:0] sel_b();
        return {if_b.s3, if_b.s2, if_b.s1, if_b.s0};
    endfunction

    // Called at a negedge; returns at the negedge after the edge that sampled start.
    task automatic pulse_start_a();
        if_a.start = 1'b1;
        @(negedge clk);
        if_a.start = 1'b0;
        e0 = edge_cnt;
    endtask

    task automatic wait_done_a(input string tag, input int exp_edges, output bit saw_idle);
        bit found;
        found    = 1'b0;
        saw_idle = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (if_a.busy !== 1'b1) saw_idle = 1'b1;
            if (if_a.done === 1'b1) found = 1'b1;
        end
        if (!found) check_val({tag, "_timeout"}, 0, 1);
        else check_val({tag, "_edges"}, edge_cnt - e0, exp_edges);
    endtask

    task automatic wait_sel_a(input string tag, input logic [3:0] target);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (sel_a() == target) found = 1'b1;
        end
        if (!found) check_val({tag, "_sel_timeout"}, 0, 1);
    endtask

    initial begin
        bit idle;
        checks          = 0;
        failures        = 0;
        e0              = 0;
        rst_n           = 1'b0;
        mux_d           = 16'hAAAA;
        if_a.start      = 1'b1;
        if_a.continuous = 1'b0;
        if_a.abort      = 1'b0;
        if_b.start      = 1'b0;
        if_b.continuous = 1'b0;
        if_b.abort      = 1'b0;

        repeat (3) @(negedge clk);
        check_val("rst_sel", {28'h0, sel_a()}, 0);
        check_val("rst_busy", {31'h0, if_a.busy}, 0);
        check_val("rst_done", {31'h0, if_a.done}, 0);
        check_val("rst_data", {16'h0, if_a.data_out}, 0);

        // Start held through reset: accepted on the first edge after release.
        exp_a.push_back(16'hAAAA);
        rst_n = 1'b1;
        pulse_start_a();
        check_val("s1_busy_after_start", {31'h0, if_a.busy}, 1);
        wait_done_a("s1_done", 32, idle);
        check_val("s1_busy_falls_with_done", {31'h0, if_a.busy}, 0);
        @(negedge clk);
        check_val("s1_done_one_cycle", {31'h0, if_a.done}, 0);

        // Abort at channel 7: no expectation pushed, so any done is spurious.
        pulse_start_a();
        wait_sel_a("abort", 4'd7);
        if_a.abort = 1'b1;
        @(negedge clk);
        if_a.abort = 1'b0;
        check_val("abort_busy", {31'h0, if_a.busy}, 0);
        check_val("abort_sel", {28'h0, sel_a()}, 0);
        check_val("abort_done", {31'h0, if_a.done}, 0);
        check_val("abort_data_kept", {16'h0, if_a.data_out}, 16'hAAAA);
        repeat (40) @(negedge clk);
        check_val("abort_stays_idle", {31'h0, if_a.busy}, 0);

        // Start re-pulsed mid-scan is ignored.
        exp_a.push_back(16'hAAAA);
        pulse_start_a();
        wait_sel_a("restart", 4'd4);
        if_a.start = 1'b1;
        @(negedge clk);
        if_a.start = 1'b0;
        wait_done_a("restart_done", 32, idle);
        repeat (40) @(negedge clk);
        check_val("restart_no_second_scan", {31'h0, if_a.busy}, 0);

        // Start and abort together in IDLE.
        if_a.start = 1'b1;
        if_a.abort = 1'b1;
        @(negedge clk);
        if_a.start = 1'b0;
        if_a.abort = 1'b0;
        check_val("start_abort_busy", {31'h0, if_a.busy}, 0);
        repeat (3) @(negedge clk);
        check_val("start_abort_sel", {28'h0, sel_a()}, 0);

        // Continuous mode: data inverted after the first word, then continuous dropped.
        exp_a.push_back(16'hAAAA);
        exp_a.push_back(16'h5555);
        exp_a.push_back(16'h5555);
        if_a.continuous = 1'b1;
        pulse_start_a();
        wait_done_a("cont1", 32, idle);
        check_val("cont1_busy_held", {31'h0, if_a.busy}, 1);
        mux_d = 16'h5555;
        e0    = edge_cnt;
        wait_done_a("cont2", 32, idle);
        check_val("cont2_busy_never_dropped", {31'h0, idle}, 0);
        if_a.continuous = 1'b0;
        e0 = edge_cnt;
        wait_done_a("cont3", 32, idle);
        check_val("cont3_idle_after", {31'h0, if_a.busy}, 0);
        mux_d = 16'hAAAA;

        // Settle of 3 cycles: each select value held four cycles.
        exp_b.push_back(16'hAAAA);
        if_b.start = 1'b1;
        @(negedge clk);
        if_b.start = 1'b0;
        for (int n = 0; n < 64; n++) begin
            check_val($sformatf("b_sel_%0d", n), {28'h0, sel_b()}, n / 4);
            @(negedge clk);
        end
        check_val("b_done_edge64", {31'h0, if_b.done}, 1);
        check_val("b_busy_falls", {31'h0, if_b.busy}, 0);

        // Asynchronous reset in the middle of a scan.
        exp_a.push_back(16'hAAAA);
        pulse_start_a();
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_busy", {31'h0, if_a.busy}, 0);
        check_val("arst_sel", {28'h0, sel_a()}, 0);
        check_val("arst_data", {16'h0, if_a.data_out}, 0);
        check_val("arst_done", {31'h0, if_a.done}, 0);
        exp_a.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_val("arst_waits_idle", {31'h0, if_a.busy}, 0);
        exp_a.push_back(16'hAAAA);
        pulse_start_a();
        wait_done_a("arst_rescan", 32, idle);
        repeat (2) @(negedge clk);
        check_val("exp_queue_drained", exp_a.size() + exp_b.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux16_scan.md
MUX16_SCAN -- requirements
Module: mux16_scan

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1, number of cycles each select value is held before sampling y (legal range 1..15).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request a 16-channel scan; sampled only in IDLE.
REQ-005 continuous  input  1  when 1, a completed scan restarts immediately at channel 0.
REQ-006 abort  input  1  terminate scan; return to IDLE without updating data_out.
REQ-007 y  input  1  output of the downstream 16:1 mux (mux16.y).
REQ-008 s0, s1, s2, s3  output  1 each  select bits driven to mux16.s0..s3; s3 is MSB.
REQ-009 data_out  output  16  last completed scan; bit k holds y sampled with select = k.
REQ-010 done  output  1  one-cycle pulse when data_out is updated.
REQ-011 busy  output  1  high in SETTLE and SAMPLE states.

Function
REQ-012 FSM states: IDLE, SETTLE, SAMPLE; all outputs are registered.
REQ-013 IDLE: start=1 at an edge -> SETTLE, sel=0, settle count=0, busy=1 after that edge.
REQ-014 SETTLE: count increments each cycle; SETTLE lasts exactly SETTLE_CYCLES cycles, then -> SAMPLE.
REQ-015 SAMPLE lasts one cycle; at its ending edge shadow[sel] <= y.
REQ-016 SAMPLE with sel<15: sel <= sel+1, count <= 0, -> SETTLE.
REQ-017 SAMPLE with sel=15: data_out <= {y, shadow[14:0]}, done <= 1 for one cycle, sel <= 0.
REQ-018 After REQ-017: continuous=1 -> SETTLE (busy stays 1); continuous=0 -> IDLE (busy <= 0).
REQ-019 Timing: start sampled at edge E -> channel k captured at edge E+(k+1)(SETTLE_CYCLES+1); done high after edge E+16(SETTLE_CYCLES+1).
REQ-020 s3..s0 equal sel at all times, stable for the entire SETTLE+SAMPLE window of each channel.
REQ-021 start while busy is ignored; it neither restarts nor queues a scan.
REQ-022 continuous deasserted mid-scan: current scan completes, done pulses, then IDLE.
REQ-023 abort=1 in any state -> IDLE, sel=0, busy=0, done=0, data_out unchanged, shadow contents discarded.
REQ-024 abort and start together in IDLE -> abort wins; remain IDLE.
REQ-025 abort coincident with the final SAMPLE edge -> abort wins; no done, data_out unchanged.
REQ-026 In IDLE sel holds 0 and done is 0.

Reset
REQ-027 rst_n=0 asynchronously forces state=IDLE, sel=0 (s3..s0=0000), count=0, shadow=0, data_out=16'h0000, done=0, busy=0.
REQ-028 Reset asserted mid-scan discards the scan; after release the block waits in IDLE for start.
REQ-029 The first edge after rst_n rises may accept start.

Structure
REQ-030 Shared package holds MUX_CH=16, SEL_W=4 and the state enumeration (IDLE, SETTLE, SAMPLE).
REQ-031 No sub-module: counter and FSM are inline; mux16 is instantiated by the parent alongside this block, not inside it.
REQ-032 The settle counter is sized to hold SETTLE_CYCLES; sel is SEL_W bits and wraps 15->0 only via REQ-017.

Verification (bench instantiates mux16_scan driving a real mux16)
REQ-033 mux data d0..d15 = 0,1,0,1,...; SETTLE_CYCLES=1; pulse start -> done after 32 edges, data_out=16'hAAAA, busy falls with done.
REQ-034 Same data, SETTLE_CYCLES=3 -> done at edge 64; s3..s0 observed stepping 0000..1111, each value held 4 cycles.
REQ-035 continuous=1, d inverted after first done -> second done 32 cycles later with data_out=16'h5555; busy never drops.
REQ-036 abort at channel 7 after a prior scan gave 16'hAAAA -> IDLE next cycle, no done, data_out stays 16'hAAAA, s3..s0=0000.
REQ-037 start re-pulsed at channel 4 -> ignored; done still at original edge 32; start+abort together in IDLE -> stays IDLE.
REQ-038 rst_n pulled low mid-scan (between edges) -> outputs reset immediately; after release a new start yields correct data_out at edge 32.
